// File: rtl/i2c_scl_gen.sv
// I2C master bit-clock generator: four-quadrant SCL/data strobes with
// synchronised slave clock-stretch detection, stretch timeout and bit tick.
module i2c_scl_gen #(
    parameter int DIVIDER         = 70000,
    parameter int SYNC_STAGES     = 2,
    parameter int STRETCH_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       scl_in,
    input  logic       stretch_en,
    input  logic       clr_err,
    output logic       scl_clk,
    output logic       data_clk,
    output logic [1:0] phase,
    output logic       switch_range,
    output logic       stretching,
    output logic       timeout_err,
    output logic       tick
);
    localparam int CBITS = $clog2(4 * DIVIDER);
    localparam int TBITS = $clog2(STRETCH_TIMEOUT + 1);

    localparam logic [CBITS-1:0] CNT_LAST = CBITS'(4 * DIVIDER - 1);
    localparam logic [CBITS-1:0] Q1_START = CBITS'(DIVIDER);
    localparam logic [CBITS-1:0] Q2_START = CBITS'(2 * DIVIDER);
    localparam logic [CBITS-1:0] Q3_START = CBITS'(3 * DIVIDER);
    // Sample SCL only once the synchroniser has seen our own release at Q2 start.
    localparam logic [CBITS-1:0] CHK_POINT = CBITS'(2 * DIVIDER + SYNC_STAGES);
    localparam logic [TBITS-1:0] TCNT_LAST = TBITS'(STRETCH_TIMEOUT - 1);

    logic [CBITS-1:0]       cnt_q, cnt_d;
    logic [TBITS-1:0]       tcnt_q, tcnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   scl_s;
    logic                   hold;

    logic       scl_clk_q, scl_clk_d;
    logic       data_clk_q, data_clk_d;
    logic [1:0] phase_q, phase_d;
    logic       switch_range_q, switch_range_d;
    logic       stretching_q, stretching_d;
    logic       timeout_err_q, timeout_err_d;
    logic       tick_q, tick_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], scl_in};
    assign scl_s  = sync_q[SYNC_STAGES-1];
    assign hold   = (cnt_q == CHK_POINT) && stretch_en && !scl_s && !timeout_err_q;

    always_comb begin
        cnt_d          = cnt_q;
        tcnt_d         = tcnt_q;
        timeout_err_d  = timeout_err_q;
        stretching_d   = 1'b0;
        tick_d         = 1'b0;
        if (clr_err) begin
            timeout_err_d = 1'b0;
        end
        if (!ena) begin
            cnt_d  = '0;
            tcnt_d = '0;
        end else if (hold && (tcnt_q != TCNT_LAST)) begin
            tcnt_d       = tcnt_q + TBITS'(1);
            stretching_d = 1'b1;
        end else begin
            // A hold that reaches here has exhausted its budget; setting wins over clr_err.
            if (hold) begin
                timeout_err_d = 1'b1;
            end
            tcnt_d = '0;
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CBITS'(1);
            end
        end
    end

    // Outputs decode the count being written this edge so they never lag cnt.
    always_comb begin
        phase_d        = 2'd0;
        scl_clk_d      = 1'b1;
        data_clk_d     = 1'b0;
        switch_range_d = 1'b0;
        if (ena) begin
            if (cnt_d < Q1_START) begin
                phase_d = 2'd0;
            end else if (cnt_d < Q2_START) begin
                phase_d = 2'd1;
            end else if (cnt_d < Q3_START) begin
                phase_d = 2'd2;
            end else begin
                phase_d = 2'd3;
            end
            scl_clk_d      = phase_d[1];
            data_clk_d     = phase_d[1] ^ phase_d[0];
            switch_range_d = (phase_d == 2'd2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q          <= '0;
            tcnt_q         <= '0;
            sync_q         <= '1;
            scl_clk_q      <= 1'b1;
            data_clk_q     <= 1'b0;
            phase_q        <= 2'd0;
            switch_range_q <= 1'b0;
            stretching_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
            tick_q         <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            tcnt_q         <= tcnt_d;
            sync_q         <= sync_d;
            scl_clk_q      <= scl_clk_d;
            data_clk_q     <= data_clk_d;
            phase_q        <= phase_d;
            switch_range_q <= switch_range_d;
            stretching_q   <= stretching_d;
            timeout_err_q  <= timeout_err_d;
            tick_q         <= tick_d;
        end
    end

    assign scl_clk      = scl_clk_q;
    assign data_clk     = data_clk_q;
    assign phase        = phase_q;
    assign switch_range = switch_range_q;
    assign stretching   = stretching_q;
    assign timeout_err  = timeout_err_q;
    assign tick         = tick_q;

endmodule
